// File: rtl/vending_pkg.sv
// Shared types, default price table and coin decoding for the multi-product
// vending controller.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_VEND    = 3'd3,
        ST_REJECT  = 3'd4,
        ST_CHANGE  = 3'd5
    } state_e;

    localparam int COIN_VAL_W       = 8;
    localparam int DEF_NUM_PRODUCTS = 4;
    localparam int DEF_CREDIT_W     = 9;

    // Product 0 sits in the least significant slice.
    localparam logic [DEF_NUM_PRODUCTS*DEF_CREDIT_W-1:0] DEF_PRICES =
        {9'd150, 9'd100, 9'd50, 9'd10};

    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] coin_type);
        logic [COIN_VAL_W-1:0] val;
        case (coin_type)
            2'd0:    val = 8'd10;
            2'd1:    val = 8'd20;
            2'd2:    val = 8'd100;
            2'd3:    val = 8'd50;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vending_if.sv
// Front-panel, coin acceptor, dispense and change-hopper signals of the
// vending controller; slave is the controller side, master the environment.
interface vending_if #(
    parameter int SEL_W    = 2,
    parameter int CREDIT_W = 9,
    parameter int STOCK_W  = 4
);
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_product;
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                coin_done;
    logic                cancel;
    logic                drop_done;
    logic                restock_valid;
    logic [SEL_W-1:0]    restock_product;
    logic [STOCK_W-1:0]  restock_count;
    logic                motor;
    logic [2:0]          led;
    logic [CREDIT_W-1:0] credit;
    logic                sold_out;
    logic                coin_reject;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amount;
    logic                change_ack;

    modport slave (
        input  sel_valid, sel_product, coin_valid, coin_type, coin_done, cancel,
               drop_done, restock_valid, restock_product, restock_count, change_ack,
        output motor, led, credit, sold_out, coin_reject, change_valid, change_amount
    );

    modport master (
        output sel_valid, sel_product, coin_valid, coin_type, coin_done, cancel,
               drop_done, restock_valid, restock_product, restock_count, change_ack,
        input  motor, led, credit, sold_out, coin_reject, change_valid, change_amount
    );
endinterface

// File: rtl/vending_credit.sv
// Credit accumulator: decodes coins, refuses any coin that would overflow the
// credit register or arrives outside collection, and applies price/refund updates.
module vending_credit #(
    parameter int CREDIT_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                accept_en,
    input  logic                sub_en,
    input  logic [CREDIT_W-1:0] sub_amt,
    input  logic                clear,
    output logic [CREDIT_W-1:0] credit_d,
    output logic [CREDIT_W-1:0] credit_q,
    output logic                coin_reject_q
);
    import vending_pkg::*;

    logic [CREDIT_W:0] sum_s;
    logic              coin_ok_s;
    logic              coin_reject_d;

    // A carry out of the sum means the coin would clip, so it is refused whole.
    always_comb begin
        sum_s         = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_type));
        coin_ok_s     = coin_valid && accept_en && !sum_s[CREDIT_W];
        coin_reject_d = coin_valid && !coin_ok_s;
        if (clear) begin
            credit_d = '0;
        end else if (sub_en) begin
            credit_d = credit_q - sub_amt;
        end else if (coin_ok_s) begin
            credit_d = sum_s[CREDIT_W-1:0];
        end else begin
            credit_d = credit_q;
        end
    end

    // Credit and reject-pulse registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
        end
    end

endmodule

// File: rtl/vending_ctrl.sv
// Multi-product vending controller: selection with stock tracking, coin
// collection with timeout, price check, dispense and handshaked change return.
module vending_ctrl #(
    parameter int NUM_PRODUCTS   = 4,
    parameter int CREDIT_W       = 9,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = vending_pkg::DEF_PRICES,
    parameter int STOCK_W        = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic      clk,
    input logic      reset,
    vending_if.slave bus
);
    import vending_pkg::*;

    localparam int SEL_W   = $clog2(NUM_PRODUCTS);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    prod_q, prod_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [STOCK_W-1:0]  stock_q [NUM_PRODUCTS];
    logic [STOCK_W-1:0]  stock_d [NUM_PRODUCTS];
    logic                motor_q, motor_d;
    logic [2:0]          led_q, led_d;
    logic                sold_out_q, sold_out_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, price_s;
    logic                coin_reject_q;
    logic                accept_en_s, sub_en_s, clear_s;

    assign price_s     = PRICES[int'(prod_q)*CREDIT_W +: CREDIT_W];
    assign accept_en_s = (state_q == ST_COLLECT);
    assign sub_en_s    = (state_q == ST_CHECK) && (credit_q >= price_s);
    assign clear_s     = (state_q == ST_CHANGE) && bus.change_ack;

    vending_credit #(.CREDIT_W(CREDIT_W)) u_credit (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (bus.coin_valid),
        .coin_type     (bus.coin_type),
        .accept_en     (accept_en_s),
        .sub_en        (sub_en_s),
        .sub_amt       (price_s),
        .clear         (clear_s),
        .credit_d      (credit_d),
        .credit_q      (credit_q),
        .coin_reject_q (coin_reject_q)
    );

    // Next-state, stock and output decode; credit_d already holds a same-cycle coin.
    always_comb begin
        state_d    = state_q;
        prod_d     = prod_q;
        timer_d    = timer_q;
        stock_d    = stock_q;
        sold_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.restock_valid) begin
                    stock_d[bus.restock_product] = bus.restock_count;
                end else begin
                    stock_d = stock_q;
                end
                if (bus.sel_valid) begin
                    if (stock_q[bus.sel_product] != '0) begin
                        prod_d  = bus.sel_product;
                        timer_d = '0;
                        state_d = ST_COLLECT;
                    end else begin
                        sold_out_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (bus.cancel) begin
                    state_d = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
                end else if (bus.coin_done) begin
                    state_d = ST_CHECK;
                end else if (bus.coin_valid) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_CHECK: begin
                if (sub_en_s) begin
                    stock_d[prod_q] = stock_q[prod_q] - STOCK_W'(1);
                    state_d         = ST_VEND;
                end else begin
                    state_d = ST_REJECT;
                end
            end
            ST_REJECT: begin
                timer_d = '0;
                state_d = ST_COLLECT;
            end
            ST_VEND: begin
                if (bus.drop_done) begin
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    state_d = ST_VEND;
                end
            end
            ST_CHANGE: begin
                if (bus.change_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHANGE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        motor_d         = (state_d == ST_VEND);
        led_d           = state_d;
        change_valid_d  = (state_d == ST_CHANGE);
        change_amount_d = (state_d == ST_CHANGE) ? credit_d : '0;
    end

    // FSM state, stock table and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            prod_q          <= '0;
            timer_q         <= '0;
            motor_q         <= 1'b0;
            led_q           <= 3'd0;
            sold_out_q      <= 1'b0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_q[i] <= {STOCK_W{1'b1}};
            end
        end else begin
            state_q         <= state_d;
            prod_q          <= prod_d;
            timer_q         <= timer_d;
            motor_q         <= motor_d;
            led_q           <= led_d;
            sold_out_q      <= sold_out_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign bus.motor         = motor_q;
    assign bus.led           = led_q;
    assign bus.credit        = credit_q;
    assign bus.sold_out      = sold_out_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.change_amount = change_amount_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: a transaction-level customer model predicts
// output events, and a monitor pops and compares them as the controller shows them.
module tb_vending_ctrl;
    localparam int NP     = 4;
    localparam int SEL_W  = 2;
    localparam int CW     = 9;
    localparam int SW     = 4;
    localparam int TO     = 1000;
    localparam int MAXCR  = (1 << CW) - 1;

    localparam int K_COINREJ = 0;
    localparam int K_SOLDOUT = 1;
    localparam int K_REJECT  = 2;
    localparam int K_VEND    = 3;
    localparam int K_CHANGE  = 4;

    typedef struct {
        int kind;
        int value;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vending_if #(.SEL_W(SEL_W), .CREDIT_W(CW), .STOCK_W(SW)) vif();

    vending_ctrl #(
        .NUM_PRODUCTS   (NP),
        .CREDIT_W       (CW),
        .STOCK_W        (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    int  price_tab [NP] = '{10, 50, 100, 150};
    int  coin_tab  [4]  = '{10, 20, 100, 50};
    int  m_stock   [NP];
    int  m_credit;
    int  m_prod;
    bit  m_session;
    ev_t exp_q [$];
    int  exp_change;
    int  checks   = 0;
    int  failures = 0;
    bit  prev_motor;
    bit  prev_cv;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int value);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input string name, input int kind, input int value);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected event value=%0d t=%0t", name, value, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.value != value) begin
                failures++;
                $display("FAIL %s actual kind=%0d value=%0d expected kind=%0d value=%0d t=%0t",
                         name, kind, value, e.kind, e.value, $time);
            end
            if (e.kind == K_CHANGE) exp_change = e.value;
        end
    endtask

    // Monitor: turns DUT output activity into events and checks them in order.
    initial begin
        prev_motor = 1'b0;
        prev_cv    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (vif.coin_reject) expect_ev("coin_reject", K_COINREJ, 0);
                if (vif.sold_out) expect_ev("sold_out", K_SOLDOUT, 0);
                if (vif.led == 3'd4) expect_ev("reject_state", K_REJECT, int'(vif.credit));
                if (vif.motor && !prev_motor) expect_ev("vend_credit", K_VEND, int'(vif.credit));
                if (vif.change_valid && !prev_cv)
                    expect_ev("change_amount", K_CHANGE, int'(vif.change_amount));
                else if (vif.change_valid)
                    check("change_hold", int'(vif.change_amount), exp_change);
            end
            prev_motor = vif.motor;
            prev_cv    = vif.change_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        vif.sel_valid       = 1'b0;
        vif.sel_product     = '0;
        vif.coin_valid      = 1'b0;
        vif.coin_type       = 2'd0;
        vif.coin_done       = 1'b0;
        vif.cancel          = 1'b0;
        vif.drop_done       = 1'b0;
        vif.restock_valid   = 1'b0;
        vif.restock_product = '0;
        vif.restock_count   = '0;
        vif.change_ack      = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic m_reset();
        for (int i = 0; i < NP; i++) m_stock[i] = (1 << SW) - 1;
        m_credit   = 0;
        m_session  = 1'b0;
        m_prod     = 0;
        exp_change = 0;
        exp_q.delete();
    endtask

    task automatic drive_coin(input int t);
        vif.coin_valid = 1'b1;
        vif.coin_type  = 2'(t);
        if (!m_session || m_credit + coin_tab[t] > MAXCR) push_ev(K_COINREJ, 0);
        else m_credit += coin_tab[t];
    endtask

    task automatic do_restock(input int p, input int c);
        vif.restock_valid   = 1'b1;
        vif.restock_product = SEL_W'(p);
        vif.restock_count   = SW'(c);
        if (!m_session) m_stock[p] = c;
        strobe();
    endtask

    task automatic do_select(input int p);
        vif.sel_valid   = 1'b1;
        vif.sel_product = SEL_W'(p);
        if (m_stock[p] == 0) push_ev(K_SOLDOUT, 0);
        else begin
            m_session = 1'b1;
            m_prod    = p;
        end
        strobe();
        check("led_after_select", int'(vif.led), m_session ? 1 : 0);
    endtask

    task automatic do_coin(input int t);
        drive_coin(t);
        strobe();
        check("credit_after_coin", int'(vif.credit), m_credit);
    endtask

    task automatic take_change();
        int cyc = 0;
        while (!vif.change_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("change_offered", int'(vif.change_valid), 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        vif.change_ack = 1'b1;
        strobe();
        check("change_cleared", int'(vif.change_valid), 0);
        check("idle_after_ack", int'(vif.led), 0);
        check("credit_after_ack", int'(vif.credit), 0);
        m_credit  = 0;
        m_session = 1'b0;
    endtask

    task automatic wait_motor();
        int cyc = 1;
        while (!vif.motor && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("done_to_motor_cycles", cyc, 2);
    endtask

    task automatic do_done(input bit with_coin, input int t);
        bit vend;
        if (with_coin) drive_coin(t);
        vif.coin_done = 1'b1;
        vend = (m_credit >= price_tab[m_prod]);
        if (vend) begin
            m_credit -= price_tab[m_prod];
            m_stock[m_prod]--;
            push_ev(K_VEND, m_credit);
            if (m_credit > 0) push_ev(K_CHANGE, m_credit);
        end else begin
            push_ev(K_REJECT, m_credit);
        end
        strobe();
        if (vend) begin
            wait_motor();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vif.drop_done = 1'b1;
            strobe();
            check("motor_off_after_drop", int'(vif.motor), 0);
            if (m_credit > 0) take_change();
            else check("idle_after_vend", int'(vif.led), 0);
            m_session = 1'b0;
        end else begin
            repeat (2) @(negedge clk);
            check("led_back_to_collect", int'(vif.led), 1);
            check("credit_kept", int'(vif.credit), m_credit);
        end
    endtask

    task automatic do_cancel(input bit with_coin, input int t);
        if (with_coin) drive_coin(t);
        vif.cancel = 1'b1;
        if (m_credit > 0) push_ev(K_CHANGE, m_credit);
        strobe();
        if (m_credit > 0) take_change();
        else check("idle_after_cancel", int'(vif.led), 0);
        m_credit  = 0;
        m_session = 1'b0;
    endtask

    task automatic rand_session();
        int rounds = 0;
        if ($urandom_range(0, 3) == 0) do_restock($urandom_range(0, NP-1), $urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) begin
            drive_coin($urandom_range(0, 3));
            strobe();
        end
        if ($urandom_range(0, 7) == 0) begin
            vif.change_ack = 1'b1;
            vif.cancel     = 1'b1;
            strobe();
            check("idle_ignores_ack_cancel", int'(vif.led), 0);
        end
        do_select($urandom_range(0, NP-1));
        while (m_session) begin
            int n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) do_coin($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) do_restock($urandom_range(0, NP-1), 0);
            case ($urandom_range(0, 5))
                0:       do_cancel(1'b0, 0);
                1:       do_cancel(1'b1, $urandom_range(0, 3));
                2:       do_done(1'b1, $urandom_range(0, 3));
                default: do_done(1'b0, 0);
            endcase
            rounds++;
            if (m_session && rounds >= 4) do_cancel(1'b0, 0);
        end
    endtask

    initial begin
        int cyc;
        idle_inputs();
        m_reset();
        repeat (3) @(negedge clk);
        check("reset_led", int'(vif.led), 0);
        check("reset_motor", int'(vif.motor), 0);
        check("reset_credit", int'(vif.credit), 0);
        check("reset_change_valid", int'(vif.change_valid), 0);
        check("reset_change_amount", int'(vif.change_amount), 0);
        check("reset_sold_out", int'(vif.sold_out), 0);
        check("reset_coin_reject", int'(vif.coin_reject), 0);
        reset = 1'b1;
        @(negedge clk);

        // Product 1 with 3 x 20: vend, change 10.
        do_select(1);
        for (int i = 0; i < 3; i++) do_coin(1);
        do_done(1'b0, 0);

        // Product 3 with 100: refused, then +50 vends exactly.
        do_select(3);
        do_coin(2);
        do_done(1'b0, 0);
        do_coin(3);
        do_done(1'b0, 0);

        // Stock of 1 for product 0, then sold out.
        do_restock(0, 1);
        do_select(0);
        do_coin(0);
        do_done(1'b0, 0);
        do_select(0);

        // Credit 20 then coin 100 together with cancel refunds 120.
        do_select(2);
        do_coin(1);
        do_cancel(1'b1, 2);

        // Idle timeout refunds 10.
        do_select(2);
        do_coin(0);
        push_ev(K_CHANGE, m_credit);
        cyc = 0;
        while (!vif.change_valid && cyc < TO + 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc < TO - 1 || cyc > TO + 1) begin
            failures++;
            $display("FAIL timeout_cycles actual=%0d expected=%0d", cyc, TO);
        end
        take_change();

        // Near-full credit: 510 + 100 is refused, then vend leaves 360.
        do_select(3);
        for (int i = 0; i < 5; i++) do_coin(2);
        do_coin(0);
        do_coin(2);
        check("credit_saturated", int'(vif.credit), 510);
        do_done(1'b0, 0);

        // Reset asserted while dispensing.
        do_select(1);
        do_coin(3);
        vif.coin_done = 1'b1;
        m_credit -= price_tab[1];
        push_ev(K_VEND, m_credit);
        strobe();
        wait_motor();
        reset = 1'b0;
        @(negedge clk);
        check("reset_vend_motor", int'(vif.motor), 0);
        check("reset_vend_led", int'(vif.led), 0);
        check("reset_vend_credit", int'(vif.credit), 0);
        check("reset_vend_change", int'(vif.change_valid), 0);
        m_reset();
        reset = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 150; s++) rand_session();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
